// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network engines: FSM states, activation
// select codes and a generic signed saturation helper.
package nn_pkg;

    // Widest value the saturation helper accepts
    localparam int unsigned SAT_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_FIN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic ACT_LINEAR = 1'b0;
    localparam logic ACT_RELU   = 1'b1;

    // Clamp v to the signed range of a w-bit number (w <= SAT_MAX_W)
    function automatic logic signed [SAT_MAX_W-1:0] sat_signed(
        input logic signed [SAT_MAX_W-1:0] v,
        input int unsigned                 w
    );
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/nn_act_sat.sv
// Combinational fixed-point output stage: arithmetic right shift by FRAC_W
// (rounds toward -inf), optional ReLU, then saturation to DATA_W.
//   sum_i   : signed accumulator value (ACC_W)
//   relu_i  : 1 = clamp negatives to zero
//   res_o_c : saturated signed result (DATA_W)
module nn_act_sat
    import nn_pkg::*;
#(
    parameter int unsigned ACC_W  = 22,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned FRAC_W = 4
) (
    input  logic signed [ACC_W-1:0]  sum_i,
    input  logic                     relu_i,
    output logic signed [DATA_W-1:0] res_o_c
);

    logic signed [ACC_W-1:0]     shifted_c;
    logic signed [SAT_MAX_W-1:0] wide_c;

    always_comb begin
        shifted_c = sum_i >>> FRAC_W;
        if (relu_i && shifted_c[ACC_W-1]) begin
            shifted_c = '0;
        end
        wide_c  = sat_signed(SAT_MAX_W'(shifted_c), DATA_W);
        res_o_c = DATA_W'(wide_c);
    end

endmodule

// File: rtl/nn_layer_engine.sv
// Fully-connected layer engine: writable weight/bias memory, one serial MAC,
// N_OUT activated and saturated outputs per accepted input vector.
//   clk, reset          : clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data : weight/bias writes (IDLE only)
//   act_sel             : 0 linear, 1 ReLU, captured with the vector
//   in_valid/in_ready/in_data    : input vector handshake
//   out_valid/out_ready/out_data : result vector handshake
//   busy                : engine not in IDLE
module nn_layer_engine
    import nn_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned FRAC_W = 4,
    parameter int unsigned N_IN   = 4,
    parameter int unsigned N_OUT  = 4,
    parameter int unsigned ACC_W  = 2*DATA_W + $clog2(N_IN) + 2
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     wr_en,
    input  logic [$clog2(N_OUT*(N_IN+1))-1:0]        wr_addr,
    input  logic [DATA_W-1:0]                        wr_data,
    input  logic                                     act_sel,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [N_IN*DATA_W-1:0]                   in_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [N_OUT*DATA_W-1:0]                  out_data,
    output logic                                     busy
);

    localparam int unsigned N_WORDS = N_OUT * (N_IN + 1);
    localparam int unsigned ADDR_W  = $clog2(N_WORDS);
    localparam int unsigned IDX_W   = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int unsigned NEU_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    state_t                    state_q, state_d;
    logic signed [DATA_W-1:0]  wmem_q [N_WORDS];
    logic signed [DATA_W-1:0]  x_q [N_IN];
    logic signed [DATA_W-1:0]  x_d [N_IN];
    logic signed [DATA_W-1:0]  y_q [N_OUT];
    logic signed [DATA_W-1:0]  y_d [N_OUT];
    logic                      relu_q, relu_d;
    logic [IDX_W-1:0]          i_q, i_d;
    logic [NEU_W-1:0]          n_q, n_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      in_ready_q, in_ready_d;
    logic                      out_valid_q, out_valid_d;
    logic                      busy_q, busy_d;

    logic                      wr_hit_c;
    logic [ADDR_W-1:0]         w_addr_c;
    logic [ADDR_W-1:0]         b_addr_c;
    logic signed [2*DATA_W-1:0] prod_c;
    logic signed [ACC_W-1:0]   bias_c;
    logic signed [ACC_W-1:0]   sum_c;
    logic signed [DATA_W-1:0]  res_c;

    // Weight/bias memory addressing and datapath
    always_comb begin
        wr_hit_c = wr_en && (state_q == ST_IDLE) && (32'(wr_addr) < N_WORDS);
        w_addr_c = ADDR_W'(32'(n_q) * (N_IN + 1) + 32'(i_q));
        b_addr_c = ADDR_W'(32'(n_q) * (N_IN + 1) + N_IN);
        prod_c   = x_q[i_q] * wmem_q[w_addr_c];
        bias_c   = ACC_W'(wmem_q[b_addr_c]) <<< FRAC_W;
        sum_c    = acc_q + bias_c;
    end

    nn_act_sat #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_act_sat (
        .sum_i   (sum_c),
        .relu_i  (relu_q),
        .res_o_c (res_c)
    );

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        relu_d  = relu_q;
        i_d     = i_q;
        n_d     = n_q;
        acc_d   = acc_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    for (int k = 0; k < int'(N_IN); k++) begin
                        x_d[k] = in_data[k*DATA_W +: DATA_W];
                    end
                    relu_d  = (act_sel == ACT_RELU);
                    i_d     = '0;
                    n_d     = '0;
                    acc_d   = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                // First product of a neuron restarts the accumulator
                if (i_q == '0) begin
                    acc_d = ACC_W'(prod_c);
                end else begin
                    acc_d = acc_q + ACC_W'(prod_c);
                end
                if (i_q == IDX_W'(N_IN - 1)) begin
                    i_d     = '0;
                    state_d = ST_FIN;
                end else begin
                    i_d = i_q + IDX_W'(1);
                end
            end
            ST_FIN: begin
                y_d[n_q] = res_c;
                if (n_q == NEU_W'(N_OUT - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    n_d     = n_q + NEU_W'(1);
                    state_d = ST_MAC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            relu_q      <= 1'b0;
            i_q         <= '0;
            n_q         <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int k = 0; k < int'(N_IN); k++)  x_q[k] <= '0;
            for (int k = 0; k < int'(N_OUT); k++) y_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            relu_q      <= relu_d;
            i_q         <= i_d;
            n_q         <= n_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            x_q         <= x_d;
            y_q         <= y_d;
        end
    end

    // Weight/bias memory, cleared by reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < int'(N_WORDS); k++) wmem_q[k] <= '0;
        end else if (wr_hit_c) begin
            wmem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        for (int k = 0; k < int'(N_OUT); k++) begin
            out_data[k*DATA_W +: DATA_W] = y_q[k];
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
